// File: rtl/pipe_ctrl.sv
// Pipeline control for the IF -> ID -> EX core: redirect/flush, load-use bubble, EX stall, bus hold.
// Optional perf counters (stall_cnt_o/flush_cnt_o) are built only when CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_busy_i,
  input  logic        ex_load_i,
  input  logic        ex_reg_wen_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        bus_req_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        bus_gnt_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_BUSHOLD = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             gnt_q;
  logic             from_bus_q;
  logic             load_use;

  // EX load whose destination is read by the instruction in ID
  assign load_use = ex_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                    ((ex_rd_addr_i == rs1_addr_i) | (ex_rd_addr_i == rs2_addr_i));

  assign bus_gnt_o = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      gnt_q      <= 1'b0;
      from_bus_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      gnt_q      <= (state_next == ST_BUSHOLD);
      from_bus_q <= (state == ST_BUSHOLD);
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'h0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    if (!rst) begin
      case (state)
        ST_RUN, ST_FLUSH: begin
          if (jump_en_i) begin
            // Redirect: same outputs whether from RUN or restarting inside FLUSH
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next = ST_FLUSH;
              cnt_next   = CNT_RELOAD;
            end else begin
              state_next = ST_RUN;
              cnt_next   = '0;
            end
          end else if (state == ST_FLUSH) begin
            flush_if_id_o = 1'b1;
            if (cnt <= CNT_ONE) begin
              state_next = ST_RUN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt - CNT_ONE;
            end
          end else if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
          end else if (load_use) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end else if (bus_req_i && !from_bus_q) begin
            state_next = ST_BUSHOLD;
          end
        end

        ST_BUSHOLD: begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          if (!bus_req_i) begin
            state_next = ST_RUN;
          end
        end

        default: begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_q != {PERF_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush_if_id_o && (flush_cnt_q != {PERF_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors queue expected outputs,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_busy_i;
  logic        ex_load_i;
  logic        ex_reg_wen_i;
  logic [4:0]  ex_rd_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        bus_req_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        bus_gnt_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .ex_busy_i     (ex_busy_i),
    .ex_load_i     (ex_load_i),
    .ex_reg_wen_i  (ex_reg_wen_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .bus_req_i     (bus_req_i),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .hold_pc_o     (hold_pc_o),
    .hold_if_id_o  (hold_if_id_o),
    .hold_id_ex_o  (hold_id_ex_o),
    .flush_if_id_o (flush_if_id_o),
    .flush_id_ex_o (flush_id_ex_o),
    .bus_gnt_o     (bus_gnt_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // ctl bits: {jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, bus_gnt}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_JUMP  = 7'b1000110;
  localparam logic [6:0] E_FLUSH = 7'b0000100;
  localparam logic [6:0] E_LDUSE = 7'b0110010;
  localparam logic [6:0] E_BUSY  = 7'b0111000;
  localparam logic [6:0] E_BHOLD = 7'b0111001;
  localparam logic [6:0] E_GNT   = 7'b0000001;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] addr;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  // Apply one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input string tag, input logic r, input logic je, input logic [31:0] ja,
                     input logic busy, input logic ld, input logic wen, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic req,
                     input logic [6:0] ectl, input logic [31:0] eaddr);
    exp_t e;
    rst = r; jump_en_i = je; jump_addr_i = ja; ex_busy_i = busy;
    ex_load_i = ld; ex_reg_wen_i = wen; ex_rd_addr_i = rd;
    rs1_addr_i = rs1; rs2_addr_i = rs2; bus_req_i = req;
    e.ctl = ectl; e.addr = eaddr; e.tag = tag;
    sb.push_back(e);
    if (r) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_stall += 32'(ectl[5]);
      exp_flush += 32'(ectl[2]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [6:0] ectl);
    cyc(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ectl, 32'h0);
  endtask

  task automatic req(input string tag, input logic r, input logic v, input logic [6:0] ectl);
    cyc(tag, r, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, v, ectl, 32'h0);
  endtask

  task automatic jmp(input string tag, input logic [31:0] a, input logic busy);
    cyc(tag, 1'b0, 1'b1, a, busy, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_JUMP, a);
  endtask

  // Monitor: every cycle presents an output vector
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = sb.pop_front();
      act = {jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o, bus_gnt_o};
      checks++;
      if (act !== e.ctl || jump_addr_o !== e.addr) begin
        errors++;
        $display("FAIL %s: got ctl=%b addr=%h, want ctl=%b addr=%h",
                 e.tag, act, jump_addr_o, e.ctl, e.addr);
      end
    end
  end

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; ex_busy_i = 1'b0;
    ex_load_i = 1'b0; ex_reg_wen_i = 1'b0; ex_rd_addr_i = 5'd0;
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; bus_req_i = 1'b0;
    @(posedge clk);
    #1;
    req("reset0", 1'b1, 1'b0, E_IDLE);
    req("reset1", 1'b1, 1'b0, E_IDLE);
    idle("run_idle", E_IDLE);

    // Redirect with two flush cycles
    jmp("jump_c0", 32'h100, 1'b0);
    idle("jump_c1", E_FLUSH);
    idle("jump_c2", E_IDLE);

    // Load-use bubble and non-hazards
    cyc("ldu_rs2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, E_LDUSE, 32'h0);
    idle("ldu_after", E_IDLE);
    cyc("ldu_rd0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, E_IDLE, 32'h0);
    cyc("ldu_rs1", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, E_LDUSE, 32'h0);
    cyc("ldu_nowen", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 5'd2, 1'b0, E_IDLE, 32'h0);
    cyc("ldu_nomatch", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd7, 5'd2, 1'b0, E_IDLE, 32'h0);

    // Multi-cycle EX stall, busy beats load-use, jump beats busy
    for (int i = 0; i < 4; i++)
      cyc("busy", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, E_BUSY, 32'h0);
    idle("busy_end", E_IDLE);
    jmp("jump_busy", 32'h40, 1'b1);
    idle("jump_busy_c1", E_FLUSH);
    idle("jump_busy_c2", E_IDLE);

    // Jump during FLUSH restarts the redirect; load-use/bus_req ignored in FLUSH
    jmp("rejump_c0", 32'h100, 1'b0);
    jmp("rejump_c1", 32'h200, 1'b0);
    cyc("rejump_c2", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, E_FLUSH, 32'h0);
    idle("rejump_c3", E_IDLE);

    // Bus hold for 3 request cycles, jump ignored while held
    req("bus_c0", 1'b0, 1'b1, E_IDLE);
    req("bus_c1", 1'b0, 1'b1, E_BHOLD);
    cyc("bus_c2_jump", 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, E_BHOLD, 32'h0);
    req("bus_c3", 1'b0, 1'b0, E_BHOLD);
    idle("bus_c4", E_IDLE);

    // Re-request right after release: at least one RUN cycle before re-grant
    req("gap_c0", 1'b0, 1'b1, E_IDLE);
    req("gap_c1", 1'b0, 1'b1, E_BHOLD);
    req("gap_c2", 1'b0, 1'b0, E_BHOLD);
    req("gap_c3", 1'b0, 1'b1, E_IDLE);
    req("gap_c4", 1'b0, 1'b1, E_IDLE);
    req("gap_c5", 1'b0, 1'b1, E_BHOLD);
    req("gap_c6", 1'b0, 1'b0, E_BHOLD);
    idle("gap_c7", E_IDLE);

`ifdef CTRL_PERF_CNT_EN
    idle("perf_settle", E_IDLE);
    checks++;
    if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
      errors++;
      $display("FAIL perf_cnt: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
    end
`endif

    // Reset while in BUSHOLD: grant drops after the first reset edge
    req("rstbh_c0", 1'b0, 1'b1, E_IDLE);
    req("rstbh_c1", 1'b0, 1'b1, E_BHOLD);
    req("rstbh_c2", 1'b1, 1'b1, E_GNT);
    req("rstbh_c3", 1'b1, 1'b1, E_IDLE);
    req("rstbh_c4", 1'b0, 1'b0, E_IDLE);
    req("rstbh_c5", 1'b0, 1'b1, E_IDLE);
    req("rstbh_c6", 1'b0, 1'b0, E_BHOLD);
    idle("rstbh_c7", E_IDLE);

    // Reset while in FLUSH
    jmp("rstfl_c0", 32'h80, 1'b0);
    req("rstfl_c1", 1'b1, 1'b0, E_IDLE);
    idle("rstfl_c2", E_IDLE);

`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush)) begin
      errors++;
      $display("FAIL perf_cnt_rst: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
               stall_cnt_o, flush_cnt_o, exp_stall, exp_flush);
    end
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
